cpu_io_port: RTL and testbench

//  Parametrised I/O port between the CPU datapath and the outside world; successor to the fixed 16-bit in / 1-bit out top-level I/O.

---
 rtl/cpu_io_port_pkg.sv | 18 +
 rtl/cpu_io_port_fifo.sv | 53 +++++
 rtl/cpu_io_port.sv | 162 ++++++++++++++++
 tb/tb_cpu_io_port.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_io_port_pkg.sv
// Shared definitions for the CPU I/O port: serialiser states, line level and
// a counter-width helper that tolerates parameter values of 1.
package cpu_io_port_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_SHIFT = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    localparam logic LINE_IDLE = 1'b1;

    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cpu_io_port_fifo.sv
// Synchronous inbound FIFO. A push into a full FIFO is still taken when a pop
// frees the head slot in the same cycle.
module io_fifo #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        head,
    output logic                     pop_ok,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              full;
    logic              push_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/cpu_io_port.sv
// CPU I/O port: handshaked inbound FIFO popped by IN, and an OUT holding
// register feeding an MSB-first start/stop serialiser with a programmable bit period.
module cpu_io_port
    import cpu_io_port_pkg::*;
#(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned IN_DEPTH = 4,
    parameter int unsigned BIT_DIV  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] datain,
    input  logic              datain_valid,
    output logic              datain_ready,
    input  logic              cpu_rd_en,
    output logic [DATA_W-1:0] cpu_rd_data,
    output logic              cpu_rd_ok,
    output logic              in_empty,
    input  logic              cpu_wr_en,
    input  logic [DATA_W-1:0] cpu_wr_data,
    output logic              out_full,
    output logic              dataout,
    output logic              tx_busy
);

    localparam int unsigned CNT_W = $clog2(IN_DEPTH) + 1;
    localparam int unsigned DIV_W = cnt_w(BIT_DIV);
    localparam int unsigned BIT_W = cnt_w(DATA_W);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    logic [DATA_W-1:0] fifo_head;
    logic              fifo_pop_ok;
    logic [CNT_W-1:0]  fifo_count;

    io_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (IN_DEPTH)
    ) u_in_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (datain_valid),
        .push_data (datain),
        .pop       (cpu_rd_en),
        .head      (fifo_head),
        .pop_ok    (fifo_pop_ok),
        .empty     (in_empty),
        .count     (fifo_count)
    );

    // Ready reflects only the registered count; a same-cycle pop still lets a push in.
    assign datain_ready = (fifo_count != CNT_W'(IN_DEPTH));

    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_rd_data <= '0;
            cpu_rd_ok   <= 1'b0;
        end else begin
            cpu_rd_ok <= fifo_pop_ok;
            if (fifo_pop_ok) cpu_rd_data <= fifo_head;
        end
    end

    tx_state_t         state, state_n;
    logic [DIV_W-1:0]  div_cnt, div_n;
    logic [BIT_W-1:0]  bit_cnt, bit_n;
    logic [DATA_W-1:0] shreg, shreg_n;
    logic [DATA_W-1:0] hold, hold_n;
    logic              full_n;
    logic              dataout_n;
    logic              busy_n;
    logic              period_end;
    logic              load;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            hold     <= '0;
            out_full <= 1'b0;
            dataout  <= LINE_IDLE;
            tx_busy  <= 1'b0;
        end else begin
            state    <= state_n;
            div_cnt  <= div_n;
            bit_cnt  <= bit_n;
            shreg    <= shreg_n;
            hold     <= hold_n;
            out_full <= full_n;
            dataout  <= dataout_n;
            tx_busy  <= busy_n;
        end
    end

    always_comb begin
        state_n    = state;
        div_n      = div_cnt + 1'b1;
        bit_n      = bit_cnt;
        shreg_n    = shreg;
        hold_n     = hold;
        full_n     = out_full;
        load       = 1'b0;
        period_end = (div_cnt == DIV_LAST);

        unique case (state)
            ST_IDLE: begin
                if (out_full) begin
                    state_n = ST_START;
                    load    = 1'b1;
                end
            end
            ST_START: begin
                if (period_end) begin
                    state_n = ST_SHIFT;
                    bit_n   = BIT_LAST;
                end
            end
            ST_SHIFT: begin
                if (period_end) begin
                    if (bit_cnt == '0) begin
                        state_n = ST_STOP;
                    end else begin
                        shreg_n = shreg << 1;
                        bit_n   = bit_cnt - 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (period_end) begin
                    if (out_full) begin
                        state_n = ST_START;
                        load    = 1'b1;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase

        // Every period boundary is also a state entry or a new data bit.
        if (state == ST_IDLE || period_end) div_n = '0;

        if (load) begin
            shreg_n = hold;
            full_n  = 1'b0;
        end else if (cpu_wr_en && !out_full) begin
            hold_n = cpu_wr_data;
            full_n = 1'b1;
        end

        unique case (state_n)
            ST_START: dataout_n = 1'b0;
            ST_SHIFT: dataout_n = shreg_n[DATA_W-1];
            default:  dataout_n = LINE_IDLE;
        endcase
        busy_n = (state_n != ST_IDLE);
    end

endmodule

// File: tb/tb_cpu_io_port.sv
// Bench for cpu_io_port: table vectors, directed serial-frame sequences and
// random traffic, all checked against a queue-based model of FIFO and line.
module tb_cpu_io_port;

    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] datain = '0;
    logic          datain_valid = 1'b0;
    logic          cpu_rd_en = 1'b0;
    logic          cpu_wr_en = 1'b0;
    logic [DW-1:0] cpu_wr_data = '0;
    logic          wr3_en = 1'b0;
    logic [DW-1:0] wr3_data = '0;

    logic          datain_ready, cpu_rd_ok, in_empty, out_full, dataout, tx_busy;
    logic [DW-1:0] cpu_rd_data;
    logic          ready3, rd_ok3, empty3, full3, dout3, busy3;
    logic [DW-1:0] rd_data3;

    always #5 clk = ~clk;

    cpu_io_port #(.DATA_W(DW), .IN_DEPTH(DEPTH), .BIT_DIV(1)) dut (
        .clk(clk), .rst(rst), .datain(datain), .datain_valid(datain_valid),
        .datain_ready(datain_ready), .cpu_rd_en(cpu_rd_en), .cpu_rd_data(cpu_rd_data),
        .cpu_rd_ok(cpu_rd_ok), .in_empty(in_empty), .cpu_wr_en(cpu_wr_en),
        .cpu_wr_data(cpu_wr_data), .out_full(out_full), .dataout(dataout), .tx_busy(tx_busy)
    );

    cpu_io_port #(.DATA_W(DW), .IN_DEPTH(DEPTH), .BIT_DIV(3)) dut3 (
        .clk(clk), .rst(rst), .datain(datain), .datain_valid(datain_valid),
        .datain_ready(ready3), .cpu_rd_en(cpu_rd_en), .cpu_rd_data(rd_data3),
        .cpu_rd_ok(rd_ok3), .in_empty(empty3), .cpu_wr_en(wr3_en),
        .cpu_wr_data(wr3_data), .out_full(full3), .dataout(dout3), .tx_busy(busy3)
    );

    int unsigned checks = 0;
    int unsigned passed = 0;

    // Reference model state
    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_rd_data = '0;
    logic          m_rd_ok = 1'b0;
    bit            lq1[$];
    bit            lq3[$];
    logic          pend1 = 1'b0, pend3 = 1'b0;
    logic [DW-1:0] hold1 = '0, hold3 = '0;
    logic          m_dout1 = 1'b1, m_busy1 = 1'b0, m_dout3 = 1'b1, m_busy3 = 1'b0;

    logic          rec_on = 1'b0;
    logic [1:0]    rec1[$];
    logic [1:0]    rec3[$];

    typedef struct {
        logic          v;
        logic [DW-1:0] d;
        logic          rd;
        logic          ok;
        logic [DW-1:0] rdata;
        logic          rdy;
        logic          emp;
    } vec_t;

    vec_t tbl[21];

    function automatic vec_t mk(input logic v, input logic [DW-1:0] d, input logic rd,
                                input logic ok, input logic [DW-1:0] rdata,
                                input logic rdy, input logic emp);
        vec_t r;
        r.v = v; r.d = d; r.rd = rd; r.ok = ok; r.rdata = rdata; r.rdy = rdy; r.emp = emp;
        return r;
    endfunction

    // Frame position 0 is the start bit, 1..DW are data MSB first, DW+1 is stop.
    function automatic logic frame_level(input logic [DW-1:0] w, input int unsigned i);
        if (i == 0) return 1'b0;
        if (i == DW + 1) return 1'b1;
        return w[DW - i];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp)
            $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
        else
            passed++;
    endtask

    task automatic model_edge();
        logic pop_ok, push_ok, acc1, acc3;
        if (rst) begin
            mq.delete();
            m_rd_data = '0;
            m_rd_ok   = 1'b0;
            lq1.delete();
            lq3.delete();
            pend1 = 1'b0;
            pend3 = 1'b0;
            m_dout1 = 1'b1; m_busy1 = 1'b0;
            m_dout3 = 1'b1; m_busy3 = 1'b0;
        end else begin
            pop_ok  = cpu_rd_en && (mq.size() > 0);
            push_ok = datain_valid && ((mq.size() < DEPTH) || pop_ok);
            m_rd_ok = pop_ok;
            if (pop_ok) m_rd_data = mq.pop_front();
            if (push_ok) mq.push_back(datain);

            acc1 = cpu_wr_en && !pend1;
            if (lq1.size() == 0 && pend1) begin
                for (int unsigned i = 0; i < DW + 2; i++) lq1.push_back(frame_level(hold1, i));
                pend1 = 1'b0;
            end
            if (acc1) begin pend1 = 1'b1; hold1 = cpu_wr_data; end
            if (lq1.size() > 0) begin m_dout1 = lq1.pop_front(); m_busy1 = 1'b1; end
            else begin m_dout1 = 1'b1; m_busy1 = 1'b0; end

            acc3 = wr3_en && !pend3;
            if (lq3.size() == 0 && pend3) begin
                for (int unsigned i = 0; i < DW + 2; i++)
                    for (int unsigned j = 0; j < 3; j++) lq3.push_back(frame_level(hold3, i));
                pend3 = 1'b0;
            end
            if (acc3) begin pend3 = 1'b1; hold3 = wr3_data; end
            if (lq3.size() > 0) begin m_dout3 = lq3.pop_front(); m_busy3 = 1'b1; end
            else begin m_dout3 = 1'b1; m_busy3 = 1'b0; end
        end
    endtask

    task automatic compare_all();
        logic exp_rdy, exp_emp;
        exp_rdy = (mq.size() < DEPTH);
        exp_emp = (mq.size() == 0);
        check("rd_ok",      cpu_rd_ok,    m_rd_ok);
        check("rd_data",    cpu_rd_data,  m_rd_data);
        check("ready",      datain_ready, exp_rdy);
        check("in_empty",   in_empty,     exp_emp);
        check("out_full",   out_full,     pend1);
        check("dataout",    dataout,      m_dout1);
        check("tx_busy",    tx_busy,      m_busy1);
        check("rd_ok3",     rd_ok3,       m_rd_ok);
        check("rd_data3",   rd_data3,     m_rd_data);
        check("ready3",     ready3,       exp_rdy);
        check("in_empty3",  empty3,       exp_emp);
        check("out_full3",  full3,        pend3);
        check("dataout3",   dout3,        m_dout3);
        check("tx_busy3",   busy3,        m_busy3);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
        if (rec_on) begin
            rec1.push_back({tx_busy, dataout});
            rec3.push_back({busy3, dout3});
        end
    endtask

    initial begin
        int unsigned nb;
        logic [DW-1:0] w1, w2;
        logic exp_lvl, exp_busy;

        tbl[0]  = mk(1, 16'hA5C3, 0, 0, 16'h0000, 1, 0);
        tbl[1]  = mk(1, 16'h0001, 0, 0, 16'h0000, 1, 0);
        tbl[2]  = mk(1, 16'hFFFF, 0, 0, 16'h0000, 1, 0);
        tbl[3]  = mk(1, 16'h8000, 0, 0, 16'h0000, 0, 0);
        tbl[4]  = mk(1, 16'h1234, 0, 0, 16'h0000, 0, 0);
        tbl[5]  = mk(0, 16'h0000, 1, 1, 16'hA5C3, 1, 0);
        tbl[6]  = mk(0, 16'h0000, 1, 1, 16'h0001, 1, 0);
        tbl[7]  = mk(0, 16'h0000, 1, 1, 16'hFFFF, 1, 0);
        tbl[8]  = mk(0, 16'h0000, 1, 1, 16'h8000, 1, 1);
        tbl[9]  = mk(0, 16'h0000, 1, 0, 16'h8000, 1, 1);
        tbl[10] = mk(1, 16'h1111, 0, 0, 16'h8000, 1, 0);
        tbl[11] = mk(1, 16'h2222, 0, 0, 16'h8000, 1, 0);
        tbl[12] = mk(1, 16'h3333, 0, 0, 16'h8000, 1, 0);
        tbl[13] = mk(1, 16'h4444, 0, 0, 16'h8000, 0, 0);
        tbl[14] = mk(1, 16'h5555, 1, 1, 16'h1111, 0, 0);
        tbl[15] = mk(0, 16'h0000, 1, 1, 16'h2222, 1, 0);
        tbl[16] = mk(0, 16'h0000, 1, 1, 16'h3333, 1, 0);
        tbl[17] = mk(0, 16'h0000, 1, 1, 16'h4444, 1, 0);
        tbl[18] = mk(0, 16'h0000, 1, 1, 16'h5555, 1, 1);
        tbl[19] = mk(1, 16'h6666, 1, 0, 16'h5555, 1, 0);
        tbl[20] = mk(0, 16'h0000, 1, 1, 16'h6666, 1, 1);

        repeat (3) cycle();
        rst = 1'b0;

        // Reset held 3 cycles in the middle of a frame with data in the FIFO
        datain_valid = 1'b1; datain = 16'hA5C3;
        cpu_wr_en = 1'b1; cpu_wr_data = 16'h1234;
        cycle();
        datain_valid = 1'b0; cpu_wr_en = 1'b0;
        repeat (6) cycle();
        check("t1_busy_before_rst", tx_busy, 1'b1);
        rst = 1'b1;
        cycle();
        check("t1_dout_first_edge", dataout, 1'b1);
        cycle();
        cycle();
        check("t1_dataout", dataout, 1'b1);
        check("t1_tx_busy", tx_busy, 1'b0);
        check("t1_out_full", out_full, 1'b0);
        check("t1_in_empty", in_empty, 1'b1);
        check("t1_ready", datain_ready, 1'b1);
        check("t1_rd_data", cpu_rd_data, 16'h0000);
        rst = 1'b0;

        for (int unsigned i = 0; i < 21; i++) begin
            datain_valid = tbl[i].v;
            datain       = tbl[i].d;
            cpu_rd_en    = tbl[i].rd;
            cycle();
            check($sformatf("tbl%0d_rd_ok", i),   cpu_rd_ok,    tbl[i].ok);
            check($sformatf("tbl%0d_rd_data", i), cpu_rd_data,  tbl[i].rdata);
            check($sformatf("tbl%0d_ready", i),   datain_ready, tbl[i].rdy);
            check($sformatf("tbl%0d_empty", i),   in_empty,     tbl[i].emp);
        end
        datain_valid = 1'b0; cpu_rd_en = 1'b0;
        cycle();

        // Single frame, BIT_DIV = 1
        w1 = 16'hA5C3;
        cpu_wr_en = 1'b1; cpu_wr_data = w1;
        cycle();
        cpu_wr_en = 1'b0;
        rec1.delete(); rec_on = 1'b1;
        repeat (20) cycle();
        rec_on = 1'b0;
        nb = 0;
        for (int unsigned i = 0; i < 20; i++) begin
            exp_lvl  = (i < 18) ? frame_level(w1, i) : 1'b1;
            exp_busy = (i < 18);
            check($sformatf("t4_line%0d", i), rec1[i][0], exp_lvl);
            check($sformatf("t4_busy%0d", i), rec1[i][1], exp_busy);
            if (rec1[i][1]) nb++;
        end
        check("t4_busy_cycles", nb, 18);

        // Back-to-back frames; a write while the holding register is occupied is lost
        w1 = 16'h3C5A; w2 = 16'h81E7;
        cpu_wr_en = 1'b1; cpu_wr_data = w1;
        cycle();
        cpu_wr_en = 1'b0;
        rec1.delete(); rec_on = 1'b1;
        repeat (4) cycle();
        cpu_wr_en = 1'b1; cpu_wr_data = w2;
        cycle();
        cpu_wr_en = 1'b1; cpu_wr_data = 16'hFFFF;
        cycle();
        check("t5_out_full_held", out_full, 1'b1);
        cpu_wr_en = 1'b0;
        repeat (40) cycle();
        rec_on = 1'b0;
        for (int unsigned i = 0; i < 46; i++) begin
            if (i < 18)      exp_lvl = frame_level(w1, i);
            else if (i < 36) exp_lvl = frame_level(w2, i - 18);
            else             exp_lvl = 1'b1;
            exp_busy = (i < 36);
            check($sformatf("t5_line%0d", i), rec1[i][0], exp_lvl);
            check($sformatf("t5_busy%0d", i), rec1[i][1], exp_busy);
        end

        // BIT_DIV = 3 instance: each level held three cycles
        wr3_en = 1'b1; wr3_data = 16'h0001;
        cycle();
        wr3_en = 1'b0;
        rec3.delete(); rec_on = 1'b1;
        repeat (60) cycle();
        rec_on = 1'b0;
        nb = 0;
        for (int unsigned i = 0; i < 60; i++) begin
            exp_lvl  = (i < 54) ? frame_level(16'h0001, i / 3) : 1'b1;
            exp_busy = (i < 54);
            check($sformatf("t6_line%0d", i), rec3[i][0], exp_lvl);
            check($sformatf("t6_busy%0d", i), rec3[i][1], exp_busy);
            if (rec3[i][1]) nb++;
        end
        check("t6_busy_cycles", nb, 54);

        // Random traffic on both instances with occasional resets
        for (int unsigned n = 0; n < 400; n++) begin
            rst          = ($urandom_range(0, 199) == 0);
            datain_valid = $urandom_range(0, 1) == 1;
            datain       = DW'($urandom);
            cpu_rd_en    = $urandom_range(0, 2) == 0;
            cpu_wr_en    = $urandom_range(0, 7) == 0;
            cpu_wr_data  = DW'($urandom);
            wr3_en       = $urandom_range(0, 15) == 0;
            wr3_data     = DW'($urandom);
            cycle();
        end
        rst = 1'b0; datain_valid = 1'b0; cpu_rd_en = 1'b0; cpu_wr_en = 1'b0; wr3_en = 1'b0;
        cycle();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
